// File: rtl/pb_debounce_pkg.sv
// Shared types and constants for the pb_debounce pushbutton conditioner.
package pb_pkg;

    typedef enum logic [1:0] {
        IDLE_HI = 2'd0,
        CHK_LO  = 2'd1,
        HELD_LO = 2'd2,
        CHK_HI  = 2'd3
    } pb_state_t;

    localparam int unsigned PB_DEBOUNCE_DEF = 32'd500000;
    localparam int unsigned PB_LONG_DEF     = 32'd50000000;
    localparam int unsigned PB_DEBOUNCE_SIM = 32'd4;

endpackage

// File: rtl/pb_debounce_if.sv
// Pushbutton pin and conditioned outputs; long_press exists only with PB_LONG_PRESS_EN.
interface pb_debounce_if;

    logic PB;
    logic pb_level;
    logic pressed;
    logic released;
`ifdef PB_LONG_PRESS_EN
    logic long_press;

    modport master (output PB, input pb_level, input pressed, input released, input long_press);
    modport slave  (input PB, output pb_level, output pressed, output released, output long_press);
`else
    modport master (output PB, input pb_level, input pressed, input released);
    modport slave  (input PB, output pb_level, output pressed, output released);
`endif

endinterface

// File: rtl/pb_debounce_sync2.sv
// Generic two-flop synchronizer; both stages load RST_VAL on synchronous reset.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // metastability filter for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pb_debounce.sv
// Counter-based debouncer for an active-low pushbutton with registered level and strobes.
// Optional long-press detection is built when PB_LONG_PRESS_EN is defined.
module pb_debounce
    import pb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = PB_DEBOUNCE_DEF,
    parameter int unsigned LONG_CYC     = PB_LONG_DEF
) (
    input  logic         clk,
    input  logic         rst,
    pb_debounce_if.slave bus
);

    localparam int unsigned CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned LAST_INT = (DEBOUNCE_CYC > 1) ? (DEBOUNCE_CYC - 2) : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST_INT);
    localparam logic ONE_CYC = (DEBOUNCE_CYC == 1);

    logic          s2_s;
    pb_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;
    logic          enter_held_s;
    logic          rel_qual_s;
    logic          rel_block_s;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.PB),
        .q_o (s2_s)
    );

    // The edge that leaves a stable state already counts as the first stable sample,
    // so qualification happens when the count reaches DEBOUNCE_CYC-2.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        pressed_d    = 1'b0;
        enter_held_s = 1'b0;
        rel_qual_s   = 1'b0;
        case (state_q)
            IDLE_HI: begin
                cnt_d = '0;
                if (!s2_s) begin
                    if (ONE_CYC) begin
                        state_d      = HELD_LO;
                        level_d      = 1'b0;
                        pressed_d    = 1'b1;
                        enter_held_s = 1'b1;
                    end else begin
                        state_d = CHK_LO;
                    end
                end else begin
                    state_d = IDLE_HI;
                end
            end
            CHK_LO: begin
                if (s2_s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = HELD_LO;
                    cnt_d        = '0;
                    level_d      = 1'b0;
                    pressed_d    = 1'b1;
                    enter_held_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD_LO: begin
                cnt_d = '0;
                if (s2_s) begin
                    if (ONE_CYC) begin
                        state_d    = IDLE_HI;
                        level_d    = 1'b1;
                        rel_qual_s = 1'b1;
                    end else begin
                        state_d = CHK_HI;
                    end
                end else begin
                    state_d = HELD_LO;
                end
            end
            CHK_HI: begin
                if (!s2_s) begin
                    state_d = HELD_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE_HI;
                    cnt_d      = '0;
                    level_d    = 1'b1;
                    rel_qual_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_HI;
                cnt_d   = '0;
                level_d = 1'b1;
            end
        endcase
        released_d = rel_qual_s & ~rel_block_s;
    end

    // FSM, counter and output strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE_HI;
            cnt_q      <= '0;
            level_q    <= 1'b1;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

`ifdef PB_LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);

    logic [HW-1:0] hold_q, hold_d;
    logic          long_fired_q, long_fired_d;
    logic          long_press_q, long_press_d;

    // Hold timer runs while the debounced level is low; the release edge itself is not counted.
    always_comb begin
        hold_d       = hold_q;
        long_fired_d = long_fired_q;
        long_press_d = 1'b0;
        if (enter_held_s) begin
            hold_d = '0;
        end else if (((state_q == HELD_LO) || (state_q == CHK_HI)) && !rel_qual_s) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end else begin
                hold_d = hold_q;
            end
            if ((hold_d == HOLD_MAX) && !long_fired_q) begin
                long_press_d = 1'b1;
                long_fired_d = 1'b1;
            end else begin
                long_press_d = 1'b0;
            end
        end else if (rel_qual_s) begin
            long_fired_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end
    end

    // long-press registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q       <= '0;
            long_fired_q <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            long_fired_q <= long_fired_d;
            long_press_q <= long_press_d;
        end
    end

    assign rel_block_s    = long_fired_q;
    assign bus.long_press = long_press_q;
`else
    assign rel_block_s = 1'b0;
`endif

    assign bus.pb_level = level_q;
    assign bus.pressed  = pressed_q;
    assign bus.released = released_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Self-checking bench for pb_debounce: directed scenarios plus random pin activity,
// all compared each cycle against a run-length reference model of the debounce rules.
module tb_pb_debounce;
    import pb_pkg::*;

    localparam int D  = PB_DEBOUNCE_SIM;
    localparam int LC = 20;
`ifdef PB_LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;

    // reference model state: two-sample pin history, level, run length, hold time
    bit m_h1 = 1'b1, m_h2 = 1'b1, m_lvl = 1'b1, m_fired = 1'b0;
    int m_run = 0, m_hold = 0;
    bit e_p = 1'b0, e_r = 1'b0, e_l = 1'b0;

    pb_debounce_if bus ();

    pb_debounce #(.DEBOUNCE_CYC(D), .LONG_CYC(LC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] obs();
`ifdef PB_LONG_PRESS_EN
        return {bus.pb_level, bus.pressed, bus.released, bus.long_press};
`else
        return {bus.pb_level, bus.pressed, bus.released, 1'b0};
`endif
    endfunction

    function automatic logic [3:0] expv();
        return {m_lvl, e_p, e_r, e_l};
    endfunction

    // Drive one cycle, advance the model over that edge, then settle past the edge.
    task automatic step(input logic pb, input logic r);
        bit s2n;
        @(negedge clk);
        bus.PB = pb;
        rst    = r;
        @(posedge clk);
        cyc++;
        e_p = 1'b0; e_r = 1'b0; e_l = 1'b0;
        if (r) begin
            m_h1 = 1'b1; m_h2 = 1'b1; m_lvl = 1'b1;
            m_run = 0; m_hold = 0; m_fired = 1'b0;
        end else begin
            s2n  = m_h2;
            m_h2 = m_h1;
            m_h1 = pb;
            m_run = (s2n != m_lvl) ? m_run + 1 : 0;
            if (m_run == D) begin
                m_run = 0;
                m_lvl = ~m_lvl;
                if (!m_lvl) begin
                    e_p = 1'b1;
                    m_hold = 0;
                end else begin
                    e_r = !(LONG_ON && m_fired);
                    m_fired = 1'b0;
                end
            end else if (!m_lvl && LONG_ON) begin
                if (m_hold < LC) m_hold++;
                if (m_hold == LC && !m_fired) begin
                    e_l = 1'b1;
                    m_fired = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (obs() !== 4'b1000) begin
                errs++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs(), 4'b1000);
            end
        end
    endtask

    task automatic test_clean_press();
        int j, p_at, r_at, n_r;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        j = cyc + 1; p_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                errs++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
            if (bus.pressed) p_at = cyc;
        end
        checks++;
        if (p_at !== j + D + 1) begin
            errs++;
            $display("FAIL press_latency got=%0d exp=%0d", p_at - j, D + 1);
        end
        checks++;
        if (bus.pb_level !== 1'b0) begin
            errs++;
            $display("FAIL press_level got=%b exp=0", bus.pb_level);
        end
        j = cyc + 1; r_at = -1; n_r = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                errs++;
                $display("FAIL clean_release cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
            if (bus.released) begin r_at = cyc; n_r++; end
        end
        checks++;
        if (r_at !== j + D + 1 || n_r != 1) begin
            errs++;
            $display("FAIL release_latency got=%0d count=%0d exp=%0d count=1", r_at - j, n_r, D + 1);
        end
    endtask

    task automatic test_bounce();
        int lens[13] = '{3, 1, 3, 6, 2, 1, 8, 10, 0, 0, 0, 0, 0};
        bit vals[13] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
        int n_p, p_at, j;
        n_p = 0; p_at = -1; j = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) j = cyc + 1;
            for (int i = 0; i < lens[k]; i++) begin
                step(vals[k], 1'b0);
                checks++;
                if (obs() !== expv()) begin
                    errs++;
                    $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, obs(), expv());
                end
                if (k < 4 && (bus.pressed || bus.pb_level !== 1'b1)) n_p += 100;
                if (bus.pressed) begin n_p++; p_at = cyc; end
            end
        end
        checks++;
        if (n_p != 1 || p_at !== j + D + 1) begin
            errs++;
            $display("FAIL bounce_press count=%0d at=%0d exp count=1 at=%0d", n_p, p_at - j, D + 1);
        end
    endtask

    task automatic test_mid_reset();
        int j, p_at, bad;
        bad = 0; p_at = -1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            if (obs() !== 4'b1000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL reset_quiet bad_cycles=%0d exp=0", bad);
        end
        j = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                errs++;
                $display("FAIL mid_reset cyc=%0d got=%b exp=%b", cyc, obs(), expv());
            end
            if (bus.pressed) p_at = cyc;
        end
        checks++;
        if (p_at !== j + D + 1) begin
            errs++;
            $display("FAIL mid_reset_latency got=%0d exp=%0d", p_at - j, D + 1);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    endtask

`ifdef PB_LONG_PRESS_EN
    task automatic test_long_press();
        int p_at, l_at, n_l, n_r, n_p;
        p_at = -1; l_at = -1; n_l = 0; n_r = 0; n_p = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0);
            if (bus.pressed) p_at = cyc;
            if (bus.long_press) begin l_at = cyc; n_l++; end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0);
            if (bus.released) n_r++;
            if (bus.long_press) n_l++;
        end
        checks++;
        if (n_l != 1 || l_at - p_at != LC || n_r != 0) begin
            errs++;
            $display("FAIL long_press count=%0d delay=%0d rel=%0d exp 1/%0d/0", n_l, l_at - p_at, n_r, LC);
        end
        n_r = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0);
            if (bus.pressed) n_p++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (bus.released) n_r++;
        end
        checks++;
        if (n_p != 1 || n_r != 1) begin
            errs++;
            $display("FAIL short_after_long pressed=%0d released=%0d exp 1/1", n_p, n_r);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int n_p, n_r, bad;
        bit last;
        n_p = 0; n_r = 0; bad = 0; last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < ((k == 3) ? 10 : 8); i++) begin
                step(k[0], 1'b0);
                checks++;
                if (obs() !== expv()) begin
                    errs++;
                    $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs(), expv());
                end
                if (bus.pressed && bus.released) bad++;
                if (bus.pressed) begin n_p++; if (!last) bad++; last = 1'b0; end
                if (bus.released) begin n_r++; if (last) bad++; last = 1'b1; end
            end
        end
        checks++;
        if (n_p != 2 || n_r != 2 || bad != 0) begin
            errs++;
            $display("FAIL b2b_counts pressed=%0d released=%0d order_err=%0d exp 2/2/0", n_p, n_r, bad);
        end
    endtask

    task automatic test_random();
        bit v;
        int len;
        v = 1'b1;
        for (int n = 0; n < 250; n++) begin
            v = ~v;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                step(v, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
                checks++;
                if (obs() !== expv()) begin
                    errs++;
                    $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        bus.PB = 1'b1;
        rst    = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_mid_reset();
`ifdef PB_LONG_PRESS_EN
        test_long_press();
`endif
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
